// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: streams one 512-bit block in,
// runs 64 rounds R per clock, chains digests across blocks.
module sha256_block_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int BLK_CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 init_mode,
  input  logic                 abort,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic [31:0]          msg_data,
  output logic                 dig_valid,
  input  logic                 dig_ready,
  output logic [255:0]         digest,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  if (ROUNDS_PER_CYCLE != 1 &&
      ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 4) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [5:0] RND_STEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] RND_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int          n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  logic [2:0]  state;
  logic [3:0]  widx;
  logic [5:0]  rnd;
  logic [31:0] chain [8];
  logic [31:0] wk    [8];
  logic [31:0] w     [16];
  logic [31:0] st_n  [8];
  logic [31:0] ws_n  [16];
  logic [31:0] hsum  [8];
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] wn;

  assign msg_ready = (state == S_LOAD);
  assign dig_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  // Unrolled rounds; window slot 0 always holds W[t]
  always_comb begin
    for (int i = 0; i < 8; i++) st_n[i] = wk[i];
    for (int i = 0; i < 16; i++) ws_n[i] = w[i];
    t1 = '0;
    t2 = '0;
    wn = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      t1 = st_n[7] + bsig1(st_n[4])
         + ((st_n[4] & st_n[5]) ^ (~st_n[4] & st_n[6]))
         + K[rnd + 6'(j)] + ws_n[0];
      t2 = bsig0(st_n[0])
         + ((st_n[0] & st_n[1]) ^ (st_n[0] & st_n[2])
           ^ (st_n[1] & st_n[2]));
      for (int i = 7; i > 0; i--) st_n[i] = st_n[i-1];
      st_n[4] = st_n[4] + t1;
      st_n[0] = t1 + t2;
      wn = ssig1(ws_n[14]) + ws_n[9]
         + ssig0(ws_n[1]) + ws_n[0];
      for (int i = 0; i < 15; i++) ws_n[i] = ws_n[i+1];
      ws_n[15] = wn;
    end
  end

  // Feed-forward sum of chain and working state
  always_comb begin
    for (int i = 0; i < 8; i++) hsum[i] = chain[i] + wk[i];
  end

  // Control FSM with message window and chaining state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      widx    <= '0;
      rnd     <= '0;
      digest  <= '0;
      blk_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        chain[i] <= IV[i];
        wk[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD;
            widx  <= '0;
            if (init_mode) begin
              for (int i = 0; i < 8; i++) chain[i] <= IV[i];
            end
          end
        end
        S_LOAD: begin
          if (msg_valid && msg_ready) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= msg_data;
            widx  <= widx + 4'd1;
            if (widx == 4'd15) begin
              state <= S_ROUND;
              rnd   <= '0;
              for (int i = 0; i < 8; i++) wk[i] <= chain[i];
            end
          end
        end
        S_ROUND: begin
          wk  <= st_n;
          w   <= ws_n;
          rnd <= rnd + RND_STEP;
          if (rnd == RND_LAST) state <= S_FINAL;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) chain[i] <= hsum[i];
          digest <= {hsum[0], hsum[1], hsum[2], hsum[3],
                     hsum[4], hsum[5], hsum[6], hsum[7]};
          blk_cnt <= blk_cnt + 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (dig_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Directed bench for sha256_block_engine at R=1,2,4.
// Known-answer digests, latency, stall, abort, reset.
module tb_sha256_block_engine;

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMP =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_H1 =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] D_2B =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  st = '0;
  logic [2:0]  im = '0;
  logic [2:0]  ab = '0;
  logic [2:0]  mv = '0;
  logic [2:0]  dr = '0;
  logic [31:0] md [3];
  wire  [2:0]  mr;
  wire  [2:0]  dv;
  wire  [2:0]  by;
  wire  [255:0] dg [3];
  wire  [15:0] bc [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_abc [16];
  logic [31:0] m_emp [16];
  logic [31:0] m_b1  [16];
  logic [31:0] m_b2  [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BW = (g == 2) ? 2 : 16;
    wire [BW-1:0] bc_w;
    sha256_block_engine #(
      .ROUNDS_PER_CYCLE(1 << g),
      .BLK_CNT_W(BW)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(st[g]),
      .init_mode(im[g]),
      .abort(ab[g]),
      .msg_valid(mv[g]),
      .msg_ready(mr[g]),
      .msg_data(md[g]),
      .dig_valid(dv[g]),
      .dig_ready(dr[g]),
      .digest(dg[g]),
      .busy(by[g]),
      .blk_cnt(bc_w)
    );
    assign bc[g] = 16'(bc_w);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag,
                      input int obs,
                      input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  task automatic start_blk(input int d, input bit init);
    st[d] = 1'b1;
    im[d] = init;
    tick();
    st[d] = 1'b0;
    im[d] = 1'b0;
  endtask

  task automatic send(input int d,
                      input logic [31:0] w [16],
                      input int n,
                      input bit gaps);
    int k = 0;
    int g = 0;
    bit acc;
    while (k < n && g < 2000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        mv[d] = 1'b0;
      end else begin
        mv[d] = 1'b1;
        md[d] = w[k];
      end
      acc = mv[d] && mr[d];
      tick();
      g++;
      if (acc) k++;
    end
    mv[d] = 1'b0;
    chkn("words_sent", k, n);
  endtask

  task automatic wait_out(input int d, output int lat);
    int n = 1;
    while (!dv[d] && n < 300) begin
      tick();
      n++;
    end
    lat = n;
  endtask

  task automatic take(input int d);
    dr[d] = 1'b1;
    tick();
    dr[d] = 1'b0;
  endtask

  task automatic run(input int d,
                     input logic [31:0] w [16],
                     input bit init,
                     input bit gaps,
                     input int stall,
                     input logic [255:0] exp,
                     input string tag);
    int lat;
    start_blk(d, init);
    send(d, w, 16, gaps);
    wait_out(d, lat);
    chkn({tag, "_lat"}, lat, 64 / (1 << d) + 2);
    chk({tag, "_dig"}, dg[d], exp);
    for (int c = 0; c < stall; c++) begin
      if (c == 1) st[d] = 1'b1;
      tick();
      st[d] = 1'b0;
      chkn({tag, "_hold_v"}, int'(dv[d]), 1);
      chk({tag, "_hold_d"}, dg[d], exp);
    end
    take(d);
    if (stall > 0) begin
      chkn({tag, "_idle"}, int'(by[d]), 0);
      tick();
      chkn({tag, "_no_load"}, int'(mr[d]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) md[i] = '0;
    for (int i = 0; i < 16; i++) begin
      m_abc[i] = '0;
      m_emp[i] = '0;
      m_b2[i]  = '0;
    end
    m_abc[0]  = 32'h61626380;
    m_abc[15] = 32'h00000018;
    m_emp[0]  = 32'h80000000;
    m_b2[15]  = 32'h000001c0;
    m_b1 = '{32'h61626364, 32'h62636465, 32'h63646566,
             32'h64656667, 32'h65666768, 32'h66676869,
             32'h6768696a, 32'h68696a6b, 32'h696a6b6c,
             32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
             32'h00000000};

    repeat (2) @(posedge clk);
    #1;
    chkn("rst_ready", int'(mr[0]), 0);
    chkn("rst_valid", int'(dv[0]), 0);
    chkn("rst_busy", int'(by[0]), 0);
    chk("rst_digest", dg[0], '0);
    chkn("rst_cnt", int'(bc[0]), 0);
    rst_n = 1'b1;
    tick();

    st[0] = 1'b1;
    ab[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    ab[0] = 1'b0;
    chkn("abort_beats_start", int'(by[0]), 0);

    run(0, m_abc, 1'b1, 1'b0, 0, D_ABC, "abc");
    chkn("abc_cnt", int'(bc[0]), 1);

    mv[0] = 1'b1;
    dr[0] = 1'b1;
    tick();
    tick();
    mv[0] = 1'b0;
    dr[0] = 1'b0;
    chkn("idle_stray_rdy", int'(mr[0]), 0);
    chkn("idle_stray_busy", int'(by[0]), 0);
    chkn("idle_stray_cnt", int'(bc[0]), 1);

    run(0, m_emp, 1'b1, 1'b0, 0, D_EMP, "empty");
    chkn("empty_cnt", int'(bc[0]), 2);

    run(0, m_b1, 1'b1, 1'b0, 0, D_H1, "two_b1");
    run(0, m_b2, 1'b0, 1'b0, 0, D_2B, "two_b2");
    chkn("two_cnt", int'(bc[0]), 4);

    run(0, m_b1, 1'b1, 1'b0, 0, D_H1, "ab_b1");
    start_blk(0, 1'b0);
    send(0, m_b2, 16, 1'b0);
    repeat (20) tick();
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chkn("abort_busy", int'(by[0]), 0);
    chkn("abort_valid", int'(dv[0]), 0);
    chkn("abort_cnt", int'(bc[0]), 5);
    chk("abort_digest", dg[0], D_H1);
    run(0, m_b2, 1'b0, 1'b0, 0, D_2B, "ab_b2");
    chkn("ab_cnt", int'(bc[0]), 6);

    start_blk(0, 1'b1);
    send(0, m_abc, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chkn("mid_rst_ready", int'(mr[0]), 0);
    chkn("mid_rst_valid", int'(dv[0]), 0);
    chkn("mid_rst_busy", int'(by[0]), 0);
    chk("mid_rst_digest", dg[0], '0);
    chkn("mid_rst_cnt", int'(bc[0]), 0);
    #1;
    rst_n = 1'b1;
    tick();
    run(0, m_abc, 1'b0, 1'b0, 0, D_ABC, "post_rst");
    chkn("post_rst_cnt", int'(bc[0]), 1);

    for (int d = 0; d < 3; d++) begin
      run(d, m_abc, 1'b1, 1'b1, 5, D_ABC, $sformatf("stall_r%0d", 1 << d));
    end
    chkn("r4_cnt1", int'(bc[2]), 1);

    run(2, m_emp, 1'b1, 1'b1, 0, D_EMP, "r4_emp");
    run(2, m_emp, 1'b1, 1'b0, 0, D_EMP, "r4_emp");
    chkn("r4_cnt3", int'(bc[2]), 3);
    run(2, m_emp, 1'b1, 1'b0, 0, D_EMP, "r4_emp");
    chkn("r4_wrap", int'(bc[2]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
